// File: rtl/sync_ram_dp_if.sv
// Write/read request bundle for sync_ram_dp; master issues requests, slave is the RAM.
// r_valid pulses with r_dat one cycle after an accepted read; busy means requests are dropped.
interface sync_ram_dp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LANE_WIDTH = 8
);
  localparam int NLANES = DATA_WIDTH / LANE_WIDTH;

  logic [ADDR_WIDTH-1:0] w_adr;
  logic [DATA_WIDTH-1:0] w_dat;
  logic [NLANES-1:0]     w_sel;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_valid;
  logic                  busy;

  modport master (
    output w_adr, w_dat, w_sel, w_en, r_adr, r_en,
    input  r_dat, r_valid, busy
  );

  modport slave (
    input  w_adr, w_dat, w_sel, w_en, r_adr, r_en,
    output r_dat, r_valid, busy
  );
endinterface

// File: rtl/sync_ram_dp.sv
// Simple dual-port RAM with lane write enables and a post-reset clear sweep.
// Read latency 1 cycle; no backpressure, requests are silently dropped while busy.
module sync_ram_dp #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 4,
  parameter int                    LANE_WIDTH     = 8,
  parameter int                    RDW_NEW        = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic           clk,
  input  logic           rst,
  sync_ram_dp_if.slave   bus
);
  localparam int NLANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_adr;
  logic [DATA_WIDTH-1:0] mem_dat;
  logic [NLANES-1:0]     mem_sel;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rd_old, rd_word;
  logic [DATA_WIDTH-1:0] r_dat_q;
  logic                  r_valid_q;

  // The sweep borrows the write port, so user requests are shut out until it finishes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_adr = bus.w_adr;
    mem_dat = bus.w_dat;
    mem_sel = bus.w_sel;
    rd_acc  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we  = 1'b1;
        mem_adr = cnt_q;
        mem_dat = CLEAR_VALUE;
        mem_sel = '1;
        if (cnt_q == LAST_ADR) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        mem_we = bus.w_en;
        rd_acc = bus.r_en;
      end
    endcase
    if (rst) begin
      mem_we = 1'b0;
      rd_acc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NLANES; i++) begin
        if (mem_sel[i]) begin
          mem[mem_adr][i*LANE_WIDTH +: LANE_WIDTH] <= mem_dat[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  assign rd_old = mem[bus.r_adr];

  // Write-first forwarding only touches the lanes actually being written.
  always_comb begin
    rd_word = rd_old;
    if ((RDW_NEW != 0) && mem_we && (mem_adr == bus.r_adr)) begin
      for (int i = 0; i < NLANES; i++) begin
        if (mem_sel[i]) begin
          rd_word[i*LANE_WIDTH +: LANE_WIDTH] = mem_dat[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dat_q   <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= rd_acc;
      if (rd_acc) begin
        r_dat_q <= rd_word;
      end
    end
  end

  assign bus.r_dat   = r_dat_q;
  assign bus.r_valid = r_valid_q;
  assign bus.busy    = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_sync_ram_dp.sv
// Bench for sync_ram_dp: three configurations checked cycle by cycle against an array model,
// plus directed literal expectations for clear, latency, lanes, read-during-write and reset.
module tb_sync_ram_dp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic [3:0]  wa  [3];
  logic [3:0]  ra  [3];
  logic [3:0]  ws  [3];
  logic [31:0] wd  [3];
  logic        we  [3];
  logic        re  [3];
  logic [31:0] rd  [3];
  logic        rv  [3];
  logic        bz  [3];

  sync_ram_dp_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4), .LANE_WIDTH(8)) b0 ();
  sync_ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .LANE_WIDTH(8)) b1 ();
  sync_ram_dp_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4), .LANE_WIDTH(8)) b2 ();

  assign b0.w_adr = wa[0]; assign b0.w_dat = wd[0][7:0]; assign b0.w_sel = ws[0][0:0];
  assign b0.w_en  = we[0]; assign b0.r_adr = ra[0];      assign b0.r_en  = re[0];
  assign rd[0] = {24'd0, b0.r_dat}; assign rv[0] = b0.r_valid; assign bz[0] = b0.busy;

  assign b1.w_adr = wa[1]; assign b1.w_dat = wd[1];      assign b1.w_sel = ws[1];
  assign b1.w_en  = we[1]; assign b1.r_adr = ra[1];      assign b1.r_en  = re[1];
  assign rd[1] = b1.r_dat; assign rv[1] = b1.r_valid;    assign bz[1] = b1.busy;

  assign b2.w_adr = wa[2]; assign b2.w_dat = wd[2][7:0]; assign b2.w_sel = ws[2][0:0];
  assign b2.w_en  = we[2]; assign b2.r_adr = ra[2];      assign b2.r_en  = re[2];
  assign rd[2] = {24'd0, b2.r_dat}; assign rv[2] = b2.r_valid; assign bz[2] = b2.busy;

  sync_ram_dp u0 (.clk(clk), .rst(rst[0]), .bus(b0.slave));

  sync_ram_dp #(.DATA_WIDTH(32), .LANE_WIDTH(8), .RDW_NEW(1), .CLEAR_ON_RESET(1),
                .CLEAR_VALUE(32'hC0DE_5A5A))
    u1 (.clk(clk), .rst(rst[1]), .bus(b1.slave));

  sync_ram_dp #(.RDW_NEW(1), .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'h55))
    u2 (.clk(clk), .rst(rst[2]), .bus(b2.slave));

  // Configuration table mirrored by the model.
  int          p_dw  [3] = '{8, 32, 8};
  int          p_rdw [3] = '{0, 1, 1};
  int          p_clr [3] = '{1, 1, 0};
  logic [31:0] p_cv  [3] = '{32'h0, 32'hC0DE_5A5A, 32'h55};

  int nvec  = 0;
  int nmiss = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s[%0d] got %h want %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Model: memory as an array, the clear as a count of remaining sweep cycles.
  logic [31:0] mmem     [3][16];
  int          clr_left [3];
  logic [31:0] e_rd     [3];
  logic        e_rv     [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        e_rd[k] = 32'h0;
        e_rv[k] = 1'b0;
        clr_left[k] = (p_clr[k] != 0) ? 16 : 0;
      end else if (clr_left[k] > 0) begin
        mmem[k][16 - clr_left[k]] = p_cv[k];
        clr_left[k]--;
        e_rv[k] = 1'b0;
      end else begin
        logic [31:0] old;
        old = mmem[k][ra[k]];
        if (we[k]) begin
          for (int l = 0; l < p_dw[k] / 8; l++) begin
            if (ws[k][l]) mmem[k][wa[k]][8*l +: 8] = wd[k][8*l +: 8];
          end
        end
        if (re[k]) begin
          e_rd[k] = (p_rdw[k] != 0) ? mmem[k][ra[k]] : old;
          e_rv[k] = 1'b1;
        end else begin
          e_rv[k] = 1'b0;
        end
      end
    end
  end

  logic [31:0] cmp_mask;
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        cmp_mask = (p_dw[k] == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        chk("busy", k, {31'd0, bz[k]}, {31'd0, clr_left[k] > 0});
        chk("r_valid", k, {31'd0, rv[k]}, {31'd0, e_rv[k]});
        if (!$isunknown(e_rd[k] & cmp_mask))
          chk("r_dat", k, rd[k] & cmp_mask, e_rd[k] & cmp_mask);
      end
    end
  end

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      we[k] = 1'b0;
      re[k] = 1'b0;
    end
  endtask

  int n;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; wa[k] = '0; ra[k] = '0; ws[k] = '0; wd[k] = '0; we[k] = 1'b0; re[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    chk_on = 1'b1;
    chk("rst_r_dat", 0, rd[0], 32'h0);
    chk("rst_r_dat", 1, rd[1], 32'h0);

    // Requests issued throughout the sweep must be dropped.
    we[0] = 1'b1; wa[0] = 4'd15; wd[0] = 32'hFF; ws[0] = 4'h1; re[0] = 1'b1; ra[0] = 4'd15;
    we[1] = 1'b1; wa[1] = 4'd15; wd[1] = 32'hFFFF_FFFF; ws[1] = 4'hF; re[1] = 1'b1;
    n = 0;
    while (bz[0] === 1'b1 && n < 40) begin
      n++;
      if (n == 8) wa[0] = 4'd0;
      @(negedge clk);
    end
    idle_all();
    chk("busy_len", 0, n, 16);
    chk("busy_done", 1, {31'd0, bz[1]}, 32'h0);

    re[0] = 1'b1; re[1] = 1'b1;
    for (int a = 0; a < 16; a++) begin
      ra[0] = 4'(a); ra[1] = 4'(a);
      @(negedge clk);
      chk("clr_rd", 0, rd[0], 32'h00);
      chk("clr_rv", 0, {31'd0, rv[0]}, 32'h1);
      chk("clr_rd", 1, rd[1], 32'hC0DE_5A5A);
    end
    idle_all();
    @(negedge clk);

    // Write then read latency.
    we[0] = 1'b1; wa[0] = 4'd4; wd[0] = 32'hA7; ws[0] = 4'h1;
    @(negedge clk);
    we[0] = 1'b0; re[0] = 1'b1; ra[0] = 4'd4;
    @(negedge clk);
    chk("lat_rd", 0, rd[0], 32'hA7);
    chk("lat_rv", 0, {31'd0, rv[0]}, 32'h1);
    re[0] = 1'b0;
    @(negedge clk);
    chk("hold_rv", 0, {31'd0, rv[0]}, 32'h0);
    chk("hold_rd", 0, rd[0], 32'hA7);

    // Independent ports: write addr 9 while reading addr 4.
    we[0] = 1'b1; wa[0] = 4'd9; wd[0] = 32'h42; re[0] = 1'b1; ra[0] = 4'd4;
    @(negedge clk);
    chk("indep_rd", 0, rd[0], 32'hA7);
    we[0] = 1'b0; ra[0] = 4'd9;
    @(negedge clk);
    chk("indep_rd9", 0, rd[0], 32'h42);
    re[0] = 1'b0;

    // Lane enables on the 32-bit instance.
    we[1] = 1'b1; wa[1] = 4'd2; wd[1] = 32'h1122_3344; ws[1] = 4'hF;
    @(negedge clk);
    wd[1] = 32'hAABB_CCDD; ws[1] = 4'b0101;
    @(negedge clk);
    we[1] = 1'b0; re[1] = 1'b1; ra[1] = 4'd2;
    @(negedge clk);
    chk("lane_rd", 1, rd[1], 32'h11BB_33DD);
    re[1] = 1'b0;
    we[1] = 1'b1; wd[1] = 32'hFFFF_FFFF; ws[1] = 4'h0;
    @(negedge clk);
    we[1] = 1'b0; re[1] = 1'b1;
    @(negedge clk);
    chk("sel0_noop", 1, rd[1], 32'h11BB_33DD);
    // Same-address write with partial lanes, write-first merge.
    we[1] = 1'b1; wd[1] = 32'h9988_7766; ws[1] = 4'b1010;
    @(negedge clk);
    chk("rdw_merge", 1, rd[1], 32'h99BB_77DD);
    idle_all();

    // Read-during-write: old data (inst 0) vs new data (inst 2).
    for (int k = 0; k < 3; k += 2) begin
      we[k] = 1'b1; wa[k] = 4'd7; wd[k] = 32'h5D; ws[k] = 4'h1;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k += 2) begin
      wd[k] = 32'h93; re[k] = 1'b1; ra[k] = 4'd7;
    end
    @(negedge clk);
    chk("rdw_old", 0, rd[0], 32'h5D);
    chk("rdw_new", 2, rd[2], 32'h93);
    we[0] = 1'b0; we[2] = 1'b0;
    @(negedge clk);
    chk("rdw_after", 0, rd[0], 32'h93);
    idle_all();

    // Reset in the middle of a sweep restarts it from address 0.
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (9) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    n = 0;
    while (bz[0] === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_restart", 0, n, 16);
    re[0] = 1'b1; ra[0] = 4'd4;
    @(negedge clk);
    chk("recleared", 0, rd[0], 32'h00);
    re[0] = 1'b0;

    // No-clear configuration is usable straight after reset.
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    chk("noclr_busy", 2, {31'd0, bz[2]}, 32'h0);
    we[2] = 1'b1; wa[2] = 4'd3; wd[2] = 32'h3C; ws[2] = 4'h1;
    @(negedge clk);
    chk("noclr_busy1", 2, {31'd0, bz[2]}, 32'h0);
    we[2] = 1'b0; re[2] = 1'b1; ra[2] = 4'd3;
    @(negedge clk);
    chk("noclr_rd", 2, rd[2], 32'h3C);
    chk("noclr_rv", 2, {31'd0, rv[2]}, 32'h1);
    idle_all();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end
endmodule

// File: doc/sync_ram_dp.md
Name: sync_ram_dp

Overview:
- Parametrised simple dual-port synchronous RAM: one write port and one independent read port on a single clock.
- Successor to the fixed 16x8 single-port RAM block. Adds:
  - configurable width and depth
  - per-lane write enables
  - selectable read-during-write mode
  - a hardware clear sequencer that sweeps the array after reset, with a busy flag
- Used as the generic register-file/scratch memory primitive in the design.

Parameters:
- DATA_WIDTH, 8: data word width in bits. Must be a multiple of LANE_WIDTH.
- ADDR_WIDTH, 4: address width. DEPTH = 2**ADDR_WIDTH words.
- LANE_WIDTH, 8: bits per write-enable lane. NLANES = DATA_WIDTH/LANE_WIDTH.
- RDW_NEW, 0: read-during-write to the same address. 0 returns old data; 1 returns newly written data (merged per lane).
- CLEAR_ON_RESET, 1: 1 means the clear sequencer runs after every reset; 0 means no clear, and busy stays 0.
- CLEAR_VALUE, 0: DATA_WIDTH-bit word written to every location during a clear.

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- w_adr, input, ADDR_WIDTH: write address.
- w_dat, input, DATA_WIDTH: write data.
- w_sel, input, NLANES: lane enables. Lane i covers bits [i*LANE_WIDTH +: LANE_WIDTH].
- w_en, input, 1: write request.
- r_adr, input, ADDR_WIDTH: read address.
- r_en, input, 1: read request.
- r_dat, output, DATA_WIDTH: read data.
- r_valid, output, 1: r_dat updated this cycle (one-cycle pulse).
- busy, output, 1: clear sequence in progress. Requests are ignored while high.

Behaviour:
- Reset (rst=1 at clock edge):
  - r_dat <= 0, r_valid <= 0.
  - Clear counter <= 0.
  - state <= CLEAR if CLEAR_ON_RESET, else IDLE.
  - busy <= CLEAR_ON_RESET.
  - Array contents are not touched by reset itself; only the sequencer changes them.
- FSM states are CLEAR and IDLE.
  - CLEAR:
    - each cycle writes CLEAR_VALUE to mem[cnt] (all lanes), then cnt <= cnt+1;
    - when cnt = DEPTH-1 the write occurs and state <= IDLE, busy <= 0;
    - total clear duration is exactly DEPTH cycles after the reset edge;
    - w_en and r_en are ignored, and r_valid stays 0.
  - IDLE:
    - no transitions except through rst.
- rst asserted mid-CLEAR restarts the sweep at address 0, with the full DEPTH cycles again.
- Write:
  - accepted in IDLE when w_en=1;
  - lanes with w_sel[i]=1 are updated at the clock edge; other lanes keep their value;
  - w_en=1 with w_sel=0 is a no-op.
- Read:
  - accepted in IDLE when r_en=1;
  - r_dat is registered with 1-cycle latency: at edge N, r_dat <= mem[r_adr] and r_valid <= 1 during cycle N+1;
  - r_en=0 gives r_valid <= 0 and r_dat holds its last value.
- Same-address read and write at the same edge:
  - RDW_NEW=0: r_dat gets the pre-write word.
  - RDW_NEW=1: r_dat gets the post-write word, i.e. selected lanes from w_dat and the rest from the old word.
  - Reads and writes to different addresses are fully independent.
- Address wrap: addresses are ADDR_WIDTH bits with no range check. The clear counter does not wrap past DEPTH-1.
- No initial-block contents are relied on. With CLEAR_ON_RESET=0, contents before the first write are X in simulation.

Test Plan:
- Clear sweep (defaults): pulse rst for 1 cycle.
  - Required: busy=1 for exactly 16 cycles, then 0.
  - Read of all addresses 0..15 returns 8'h00, each with r_valid one cycle after r_en.
- Write/read latency: in IDLE, write 8'hA7 to addr 4.
  - Required: next cycle, r_en with r_adr=4 gives r_dat=8'hA7 and r_valid=1 on the following cycle.
  - Required: with r_en=0 afterwards, r_valid=0 and r_dat stays 8'hA7.
- Lane enables (DATA_WIDTH=32, LANE_WIDTH=8):
  - Write 32'h11223344 to addr 2 with w_sel=4'hF.
  - Then write 32'hAABBCCDD with w_sel=4'b0101.
  - Required: read returns 32'h11BB33DD.
- Read-during-write, addr 7 holds 8'h5D; write 8'h93 to addr 7 and read addr 7 in the same cycle.
  - RDW_NEW=0 required: r_dat=8'h5D, then a subsequent read gives 8'h93.
  - RDW_NEW=1 required: r_dat=8'h93.
- Requests during busy / reset mid-clear:
  - Issue w_en to addr 15 (data 8'hFF) and r_en during CLEAR. Required: r_valid stays 0 and addr 15 reads 8'h00 after clear.
  - Assert rst at clear cycle 9. Required: busy stays high for 16 more cycles.
- CLEAR_ON_RESET=0 with CLEAR_VALUE ignored.
  - Required: busy=0 from the reset edge onward.
  - Required: a write then read in the first IDLE cycles works immediately.
